// File: rtl/alarm_ctrl.sv
// alarm_ctrl: alarm controller fed by the binary hour/minute/second outputs of
// the clock timekeeper. Holds a programmable alarm time, runs the
// ring / snooze / timeout state machine and drives a square-wave piezo buzzer.
module alarm_ctrl #(
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_MINUTES = 5,
  parameter int MAX_SNOOZE     = 3,
  parameter int TONE_DIV       = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] hour,
  input  logic [5:0] minute,
  input  logic [5:0] second,
  input  logic [5:0] key_hour,
  input  logic [5:0] key_minute,
  input  logic       set_alarm,
  input  logic       alarm_en,
  input  logic       snooze,
  input  logic       stop,
  output logic [5:0] alarm_hour,
  output logic [5:0] alarm_minute,
  output logic [1:0] state,
  output logic       ringing,
  output logic       buzzer,
  output logic       set_err
);

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_RING   = 2'b01;
  localparam logic [1:0] ST_SNOOZE = 2'b10;

  // Counter widths sized so each counter can hold its own terminal value.
  localparam int RW = (RING_SECONDS > 1) ? $clog2(RING_SECONDS) : 1;
  localparam int SW = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;
  localparam int TW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;

  localparam logic [RW-1:0] RING_LAST  = RW'(RING_SECONDS - 1);
  localparam logic [SW-1:0] SNOOZE_MAX = SW'(MAX_SNOOZE);
  localparam logic [TW-1:0] TONE_LAST  = TW'(TONE_DIV - 1);
  localparam logic [6:0]    SNZ_ADD    = 7'(SNOOZE_MINUTES);

  logic [5:0]    prev_second;
  logic [5:0]    snz_hour;
  logic [5:0]    snz_minute;
  logic [RW-1:0] ring_cnt;
  logic [SW-1:0] snooze_cnt;
  logic [TW-1:0] tone_cnt;

  logic          tick;
  logic          key_valid;
  logic [5:0]    tgt_hour;
  logic [5:0]    tgt_minute;
  logic          match;
  logic          snooze_ok;
  logic [6:0]    min_sum;
  logic          min_wrap;
  logic [5:0]    nxt_snz_hour;
  logic [5:0]    nxt_snz_minute;

  logic [1:0]    next_state;
  logic [RW-1:0] next_ring_cnt;
  logic [SW-1:0] next_snooze_cnt;
  logic          load_snz;

  assign ringing = (state == ST_RING);

  // Second strobe, key range check and the time the match compares against
  // (the snooze target while snoozing, the programmed alarm otherwise).
  always_comb begin
    tick       = (second != prev_second);
    key_valid  = (key_hour < 6'd24) && (key_minute < 6'd60);
    tgt_hour   = (state == ST_SNOOZE) ? snz_hour   : alarm_hour;
    tgt_minute = (state == ST_SNOOZE) ? snz_minute : alarm_minute;
    match      = tick && (second == 6'd0) &&
                 (hour == tgt_hour) && (minute == tgt_minute);
    snooze_ok  = (snooze_cnt < SNOOZE_MAX);
  end

  // Snooze target is the current time plus the snooze delay, with minute
  // overflow carrying into the hour and the hour wrapping past midnight.
  always_comb begin
    min_sum  = {1'b0, minute} + SNZ_ADD;
    min_wrap = (min_sum >= 7'd60);
    if (min_wrap) begin
      nxt_snz_minute = 6'(min_sum - 7'd60);
      nxt_snz_hour   = (hour >= 6'd23) ? 6'd0 : hour + 6'd1;
    end else begin
      nxt_snz_minute = min_sum[5:0];
      nxt_snz_hour   = hour;
    end
  end

  // Ring / snooze state machine. Disabling the alarm beats everything, then
  // stop, then snooze, then match / ring-timeout on the second strobe.
  always_comb begin
    next_state      = state;
    next_ring_cnt   = ring_cnt;
    next_snooze_cnt = snooze_cnt;
    load_snz        = 1'b0;
    if (!alarm_en) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (match) begin
            next_state      = ST_RING;
            next_ring_cnt   = '0;
            next_snooze_cnt = '0;
          end
        end
        ST_RING: begin
          if (stop) begin
            next_state = ST_IDLE;
          end else if (snooze && snooze_ok) begin
            next_state      = ST_SNOOZE;
            next_snooze_cnt = snooze_cnt + 1'b1;
            load_snz        = 1'b1;
          end else if (tick) begin
            if (ring_cnt == RING_LAST) begin
              next_state = ST_IDLE;
            end else begin
              next_ring_cnt = ring_cnt + 1'b1;
            end
          end
        end
        ST_SNOOZE: begin
          if (stop) begin
            next_state = ST_IDLE;
          end else if (match) begin
            next_state    = ST_RING;
            next_ring_cnt = '0;
          end
        end
        default: begin
          next_state = ST_IDLE;
        end
      endcase
    end
  end

  // State, ring/snooze counters, snooze target and the previous-second copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      ring_cnt    <= '0;
      snooze_cnt  <= '0;
      snz_hour    <= 6'd0;
      snz_minute  <= 6'd0;
      prev_second <= 6'd0;
    end else begin
      state       <= next_state;
      ring_cnt    <= next_ring_cnt;
      snooze_cnt  <= next_snooze_cnt;
      prev_second <= second;
      if (load_snz) begin
        snz_hour   <= nxt_snz_hour;
        snz_minute <= nxt_snz_minute;
      end
    end
  end

  // Alarm time load; out-of-range keys leave the registers alone and raise
  // a one-cycle error pulse instead.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alarm_hour   <= 6'd0;
      alarm_minute <= 6'd0;
      set_err      <= 1'b0;
    end else begin
      set_err <= set_alarm && !key_valid;
      if (set_alarm && key_valid) begin
        alarm_hour   <= key_hour;
        alarm_minute <= key_minute;
      end
    end
  end

  // Tone generator runs only while staying in RING; it restarts from zero on
  // every RING entry and is cleared on the same edge that leaves RING.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tone_cnt <= '0;
      buzzer   <= 1'b0;
    end else if ((state == ST_RING) && (next_state == ST_RING)) begin
      if (tone_cnt == TONE_LAST) begin
        tone_cnt <= '0;
        buzzer   <= ~buzzer;
      end else begin
        tone_cnt <= tone_cnt + 1'b1;
      end
    end else begin
      tone_cnt <= '0;
      buzzer   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alarm_ctrl.sv
// tb_alarm_ctrl: directed scenarios plus randomized time/strobe traffic for
// alarm_ctrl, checked every cycle against a behavioural model kept in minutes
// of the day, ticks remaining and cycles spent ringing.
module tb_alarm_ctrl;

  localparam int RING_SECONDS   = 3;
  localparam int SNOOZE_MINUTES = 5;
  localparam int MAX_SNOOZE     = 1;
  localparam int TONE_DIV       = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] hour, minute, second, key_hour, key_minute;
  logic       set_alarm, alarm_en, snooze, stop;
  logic [5:0] alarm_hour, alarm_minute;
  logic [1:0] state;
  logic       ringing, buzzer, set_err;

  alarm_ctrl #(
    .RING_SECONDS  (RING_SECONDS),
    .SNOOZE_MINUTES(SNOOZE_MINUTES),
    .MAX_SNOOZE    (MAX_SNOOZE),
    .TONE_DIV      (TONE_DIV)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .hour        (hour),
    .minute      (minute),
    .second      (second),
    .key_hour    (key_hour),
    .key_minute  (key_minute),
    .set_alarm   (set_alarm),
    .alarm_en    (alarm_en),
    .snooze      (snooze),
    .stop        (stop),
    .alarm_hour  (alarm_hour),
    .alarm_minute(alarm_minute),
    .state       (state),
    .ringing     (ringing),
    .buzzer      (buzzer),
    .set_err     (set_err)
  );

  // 10 ns system clock.
  always #5 clk = ~clk;

  int checkCount = 0;
  int errorCount = 0;
  bit compareOn  = 1'b0;

  // Model state: alarm as hour/minute, snooze target as minutes of the day,
  // ring progress as ticks still to go and cycles spent ringing.
  int mAlarmH, mAlarmM, mSnoozeMin, mPrevSec;
  int ticksLeft, snoozesUsed, ringCycles;
  bit mRinging, mSnoozing, mSetErr;

  task automatic checkOutput(input string name, input logic [7:0] actual, input int expected);
    checkCount++;
    if (actual !== 8'(expected)) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: advances on every clk edge from the inputs the DUT sees.
  always @(posedge clk or posedge rst) begin : model
    int curMin;
    int tgtMin;
    bit tick;
    bit match;
    bit wasRinging;
    if (rst) begin
      mAlarmH = 0; mAlarmM = 0; mSnoozeMin = 0; mPrevSec = 0;
      ticksLeft = 0; snoozesUsed = 0; ringCycles = 0;
      mRinging = 1'b0; mSnoozing = 1'b0; mSetErr = 1'b0;
    end else begin
      tick       = (int'(second) != mPrevSec);
      curMin     = int'(hour) * 60 + int'(minute);
      tgtMin     = mSnoozing ? mSnoozeMin : (mAlarmH * 60 + mAlarmM);
      match      = tick && (second == 6'd0) && (curMin == tgtMin);
      wasRinging = mRinging;
      if (!alarm_en) begin
        mRinging = 1'b0; mSnoozing = 1'b0;
      end else if (mRinging) begin
        if (stop) begin
          mRinging = 1'b0;
        end else if (snooze && snoozesUsed < MAX_SNOOZE) begin
          mRinging   = 1'b0;
          mSnoozing  = 1'b1;
          mSnoozeMin = (curMin + SNOOZE_MINUTES) % 1440;
          snoozesUsed++;
        end else if (tick) begin
          ticksLeft--;
          if (ticksLeft == 0) mRinging = 1'b0;
        end
      end else if (mSnoozing) begin
        if (stop) begin
          mSnoozing = 1'b0;
        end else if (match) begin
          mSnoozing = 1'b0; mRinging = 1'b1; ticksLeft = RING_SECONDS;
        end
      end else if (match) begin
        mRinging = 1'b1; ticksLeft = RING_SECONDS; snoozesUsed = 0;
      end
      if (mRinging && wasRinging) ringCycles++;
      else ringCycles = 0;
      mSetErr = set_alarm && !((key_hour < 6'd24) && (key_minute < 6'd60));
      if (set_alarm && !mSetErr) begin
        mAlarmH = int'(key_hour); mAlarmM = int'(key_minute);
      end
      mPrevSec = int'(second);
    end
  end

  // Compare every DUT output against the model on each falling edge.
  always @(negedge clk) begin
    if (compareOn) begin
      checkOutput("state", state, mRinging ? 1 : (mSnoozing ? 2 : 0));
      checkOutput("ringing", ringing, int'(mRinging));
      checkOutput("buzzer", buzzer, (mRinging && ((ringCycles / TONE_DIV) % 2 == 1)) ? 1 : 0);
      checkOutput("set_err", set_err, int'(mSetErr));
      checkOutput("alarm_hour", alarm_hour, mAlarmH);
      checkOutput("alarm_minute", alarm_minute, mAlarmM);
    end
  end

  task automatic cycle(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic applyStimulus(input int h, input int m, input int s, input int n);
    hour   = 6'(h);
    minute = 6'(m);
    second = 6'(s);
    cycle(n);
  endtask

  // Safety net so the run always ends.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int curSec;
    int r;
    int nm;
    rst = 1'b1;
    hour = 6'd0; minute = 6'd0; second = 6'd0;
    key_hour = 6'd0; key_minute = 6'd0;
    set_alarm = 1'b0; alarm_en = 1'b0; snooze = 1'b0; stop = 1'b0;
    cycle(2);
    checkOutput("reset_state", state, 0);
    checkOutput("reset_alarm_hour", alarm_hour, 0);
    checkOutput("reset_buzzer", buzzer, 0);
    rst = 1'b0;
    compareOn = 1'b1;

    // Load 07:30, ring at 07:30:00, tone every 4 cycles, timeout after 3 ticks.
    key_hour = 6'd7; key_minute = 6'd30; set_alarm = 1'b1;
    applyStimulus(7, 29, 59, 1);
    set_alarm = 1'b0;
    checkOutput("load_hour", alarm_hour, 7);
    checkOutput("load_minute", alarm_minute, 30);
    alarm_en = 1'b1;
    cycle(2);
    applyStimulus(7, 30, 0, 1);
    checkOutput("ring_entry_state", state, 1);
    checkOutput("ring_entry_ringing", ringing, 1);
    cycle(3);
    checkOutput("buzzer_before_toggle", buzzer, 0);
    cycle(1);
    checkOutput("buzzer_first_toggle", buzzer, 1);
    cycle(4);
    checkOutput("buzzer_second_toggle", buzzer, 0);
    applyStimulus(7, 30, 1, 3);
    applyStimulus(7, 30, 2, 3);
    checkOutput("ring_two_ticks", state, 1);
    applyStimulus(7, 30, 3, 1);
    checkOutput("ring_timeout", state, 0);
    checkOutput("timeout_buzzer", buzzer, 0);

    // Snooze to 07:35, resume, second snooze ignored, stop.
    applyStimulus(7, 29, 59, 2);
    applyStimulus(7, 30, 0, 1);
    applyStimulus(7, 30, 1, 2);
    snooze = 1'b1; cycle(1); snooze = 1'b0;
    checkOutput("snooze_state", state, 2);
    checkOutput("snooze_ringing", ringing, 0);
    applyStimulus(7, 34, 59, 2);
    checkOutput("snooze_wait", state, 2);
    applyStimulus(7, 35, 0, 1);
    checkOutput("snooze_resume", state, 1);
    snooze = 1'b1; cycle(1); snooze = 1'b0;
    checkOutput("snooze_limit", state, 1);
    stop = 1'b1; cycle(1); stop = 1'b0;
    checkOutput("stop_state", state, 0);

    // Snooze target wrapping past midnight: 23:58 + 5 -> 00:03.
    key_hour = 6'd23; key_minute = 6'd58; set_alarm = 1'b1;
    applyStimulus(23, 57, 59, 1);
    set_alarm = 1'b0;
    applyStimulus(23, 58, 0, 1);
    checkOutput("wrap_ring", state, 1);
    applyStimulus(23, 58, 1, 1);
    snooze = 1'b1; cycle(1); snooze = 1'b0;
    checkOutput("wrap_snooze", state, 2);
    applyStimulus(0, 2, 59, 2);
    applyStimulus(0, 3, 0, 1);
    checkOutput("wrap_resume", state, 1);
    stop = 1'b1; cycle(1); stop = 1'b0;

    // Rejected loads.
    key_hour = 6'd24; key_minute = 6'd0; set_alarm = 1'b1;
    cycle(1); set_alarm = 1'b0;
    checkOutput("bad_hour_err", set_err, 1);
    checkOutput("bad_hour_keep", alarm_hour, 23);
    cycle(1);
    checkOutput("err_one_cycle", set_err, 0);
    key_hour = 6'd12; key_minute = 6'd60; set_alarm = 1'b1;
    cycle(1); set_alarm = 1'b0;
    checkOutput("bad_minute_err", set_err, 1);
    checkOutput("bad_minute_keep", alarm_minute, 58);

    // Disable during RING, and no ring while disabled.
    key_hour = 6'd7; key_minute = 6'd30; set_alarm = 1'b1;
    applyStimulus(7, 29, 59, 1);
    set_alarm = 1'b0;
    applyStimulus(7, 30, 0, 1);
    cycle(4);
    checkOutput("pre_disable_buzzer", buzzer, 1);
    alarm_en = 1'b0; cycle(1);
    checkOutput("disable_state", state, 0);
    checkOutput("disable_buzzer", buzzer, 0);
    applyStimulus(7, 29, 59, 2);
    applyStimulus(7, 30, 0, 2);
    checkOutput("disabled_no_ring", state, 0);
    alarm_en = 1'b1;

    // Simultaneous stop and snooze, then async reset mid-RING.
    applyStimulus(7, 29, 59, 2);
    applyStimulus(7, 30, 0, 1);
    snooze = 1'b1; stop = 1'b1; cycle(1); snooze = 1'b0; stop = 1'b0;
    checkOutput("stop_beats_snooze", state, 0);
    applyStimulus(7, 29, 59, 2);
    applyStimulus(7, 30, 0, 1);
    cycle(4);
    checkOutput("pre_reset_buzzer", buzzer, 1);
    rst = 1'b1;
    #1;
    checkOutput("async_reset_state", state, 0);
    checkOutput("async_reset_ringing", ringing, 0);
    checkOutput("async_reset_buzzer", buzzer, 0);
    checkOutput("async_reset_alarm", alarm_minute, 0);
    cycle(1);
    rst = 1'b0;

    // Randomized traffic: time mostly advancing, occasional jumps, strobes,
    // loads aimed at the next minute and some out-of-range keys.
    curSec = 7 * 3600 + 30 * 60;
    for (int c = 0; c < 6000; c++) begin
      r = int'($urandom_range(0, 999));
      if (r < 4) curSec = int'($urandom_range(0, 86399));
      else if (r < 12) curSec = (curSec + 240) % 86400;
      else if (r < 350) curSec = (curSec + 1) % 86400;
      snooze    = ($urandom_range(0, 39) == 0);
      stop      = ($urandom_range(0, 99) == 0);
      alarm_en  = ($urandom_range(0, 299) != 0);
      set_alarm = 1'b0;
      if ($urandom_range(0, 149) == 0) begin
        set_alarm = 1'b1;
        if ($urandom_range(0, 3) == 0) begin
          key_hour   = 6'($urandom_range(0, 63));
          key_minute = 6'($urandom_range(0, 63));
        end else begin
          nm = (curSec / 60 + 1) % 1440;
          key_hour   = 6'(nm / 60);
          key_minute = 6'(nm % 60);
        end
      end
      applyStimulus(curSec / 3600, (curSec / 60) % 60, curSec % 60, 1);
    end
    snooze = 1'b0; stop = 1'b0; set_alarm = 1'b0;
    cycle(2);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
